// File: rtl/db9_splitter_sched_if.sv
// db9_splitter_sched_if: DB9 splitter scheduler signal bundle
//   db9_in     raw DB9 port CB UDLR, asynchronous
//   mode       0 = P1, 1 = P2, 2 = split, 3 = P1
//   hold       freeze schedule
//   split_sel  splitter select (0 = P1 slot, 1 = P2 slot)
//   joy_p1/p2  latched player state CB UDLR
//   sample_stb one-cycle pulse when a joy output is written
interface db9_splitter_sched_if;
  logic [5:0] db9_in;
  logic [1:0] mode;
  logic       hold;
  logic       split_sel;
  logic [5:0] joy_p1;
  logic [5:0] joy_p2;
  logic       sample_stb;
  modport master (output db9_in, mode, hold, input split_sel, joy_p1, joy_p2, sample_stb);
  modport slave (input db9_in, mode, hold, output split_sel, joy_p1, joy_p2, sample_stb);
endinterface

// File: rtl/db9_splitter_sched.sv
// db9_splitter_sched: deterministic slot scheduler sharing one DB9 port between two players
//   clk_sys  system clock
//   reset_n  asynchronous active-low reset
//   bus      db9_splitter_sched_if.slave (db9_in, mode, hold in; split_sel, joy_p1, joy_p2, sample_stb out)
//   DB9_SPLIT_DEBOUNCE_EN: when defined, a player output is written only after two matching samples
module db9_splitter_sched #(
  parameter int SLOT_CYC   = 1024,
  parameter int SETTLE_CYC = 48,
  parameter int CNT_W      = 11
) (
  input logic clk_sys,
  input logic reset_n,
  db9_splitter_sched_if.slave bus
);
  logic [5:0] s1, db9_s, joy_p1, joy_p2;
  logic [1:0] m, mode_q;
  logic [CNT_W-1:0] cnt;
  logic slot, stb, chg, wrap, smp, wr1, wr2;
`ifdef DB9_SPLIT_DEBOUNCE_EN
  logic [5:0] prev_p1, prev_p2;
`endif
  assign bus.split_sel  = slot;
  assign bus.joy_p1     = joy_p1;
  assign bus.joy_p2     = joy_p2;
  assign bus.sample_stb = stb;
  // mode 3 behaves exactly like mode 0, so it is folded before comparison
  always_comb begin
    m    = (bus.mode == 2'd3) ? 2'd0 : bus.mode;
    chg  = m != mode_q;
    wrap = cnt == CNT_W'(SLOT_CYC - 1);
    smp  = !bus.hold && !chg && cnt == CNT_W'(SETTLE_CYC);
`ifdef DB9_SPLIT_DEBOUNCE_EN
    wr1  = smp && !slot && db9_s == prev_p1;
    wr2  = smp && slot && db9_s == prev_p2;
`else
    wr1  = smp && !slot;
    wr2  = smp && slot;
`endif
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      s1    <= '0;
      db9_s <= '0;
    end else begin
      s1    <= bus.db9_in;
      db9_s <= s1;
    end
  // mode_q only advances outside hold so a change made during hold is seen after release
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      mode_q <= '0;
      cnt    <= '0;
      slot   <= 1'b0;
      joy_p1 <= '0;
      joy_p2 <= '0;
      stb    <= 1'b0;
    end else begin
      stb <= wr1 || wr2;
      if (wr1) joy_p1 <= db9_s;
      if (wr2) joy_p2 <= db9_s;
      if (!bus.hold) begin
        mode_q <= m;
        if (chg) begin
          cnt  <= '0;
          slot <= m == 2'd1;
          if (m == 2'd1) joy_p1 <= '0;
          if (m == 2'd0) joy_p2 <= '0;
        end else begin
          cnt <= wrap ? '0 : cnt + 1'b1;
          if (wrap && mode_q == 2'd2) slot <= ~slot;
        end
      end
    end
`ifdef DB9_SPLIT_DEBOUNCE_EN
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      prev_p1 <= '0;
      prev_p2 <= '0;
    end else if (!bus.hold && chg) begin
      if (m == 2'd1) prev_p1 <= '0;
      if (m == 2'd0) prev_p2 <= '0;
    end else begin
      if (smp && !slot) prev_p1 <= db9_s;
      if (smp && slot) prev_p2 <= db9_s;
    end
`endif
endmodule
